// File: rtl/ucore_port_responder_if.sv
// Request/response bus between a core (master) and the port responder (slave).
interface ucore_port_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ucore_port_responder.sv
// Single-cycle register-file responder with a two-state request/response FSM.
// Define UCORE_RESPONDER_ERR_EN to flag accesses to unimplemented registers on rsp_err.
module ucore_port_responder #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 12
) (
  input logic                  clk,
  input logic                  areset,
  ucore_port_responder_if.slave core_bus
);

  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic {StIdle, StResp} state_e;

  state_e            state_q, state_d;
  logic              init_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_sel;
  logic              err_q, err_d;
  logic              addr_ok;
  logic              accept;
  logic              req_ready;
  logic              rsp_valid;

  assign addr_ok = ({1'b0, core_bus.req_addr} < NumRegsW);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (core_bus.req_addr == ADDR_W'(i)) rd_sel = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: req_ready = init_q;
      StResp: begin
        rsp_valid = 1'b1;
        req_ready = core_bus.rsp_ready;
      end
      default: ;
    endcase

    accept = core_bus.req_valid & req_ready;

    if (accept) begin
      state_d = StResp;
    end else if (state_q == StResp && core_bus.rsp_ready) begin
      state_d = StIdle;
    end

    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      rdata_d = (!core_bus.req_write && addr_ok) ? rd_sel : '0;
`ifdef UCORE_RESPONDER_ERR_EN
      err_d   = ~addr_ok;
`else
      err_d   = 1'b0;
`endif
    end
  end

  // init_q holds req_ready low until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (accept && core_bus.req_write && addr_ok && core_bus.req_addr == ADDR_W'(i)) begin
          regs_q[i] <= core_bus.req_wdata;
        end
      end
    end
  end

  assign core_bus.req_ready = req_ready;
  assign core_bus.rsp_valid = rsp_valid;
  assign core_bus.rsp_rdata = rdata_q;
  assign core_bus.rsp_err   = err_q;

endmodule

// File: tb/tb_ucore_port_responder.sv
// Directed self-checking bench for ucore_port_responder (works with or without
// UCORE_RESPONDER_ERR_EN).
module tb_ucore_port_responder;

`ifdef UCORE_RESPONDER_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic clk;
  logic areset;
  int   n_checks;
  int   n_fail;

  ucore_port_responder_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  ucore_port_responder #(
    .DATA_W  (32),
    .ADDR_W  (4),
    .NUM_REGS(12)
  ) dut (
    .clk     (clk),
    .areset  (areset),
    .core_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got timeout, required $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic wr, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic rready);
    bus.req_valid = valid;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = rready;
    #1;
  endtask

  // One accepted transaction from IDLE or RESP-with-rsp_ready, then check the response.
  task automatic xact(input string tag, input logic wr, input logic [3:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
    drive(1'b1, wr, addr, wdata, 1'b1);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
    step();
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(1));
    check({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rdata));
    check({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    areset   = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, including with a request presented
    step();
    drive(1'b1, 1'b0, 4'd3, 32'h0, 1'b1);
    step();
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_rdata", 64'(bus.rsp_rdata), 64'(0));
    check("rst_err", 64'(bus.rsp_err), 64'(0));
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
    areset = 1'b0;
    #1;
    check("rel_req_ready_pre", 64'(bus.req_ready), 64'(0));
    step();
    check("rel_req_ready", 64'(bus.req_ready), 64'(1));
    check("rel_rsp_valid", 64'(bus.rsp_valid), 64'(0));

    // Write addr 3, then read it back-to-back while stalling the consumer
    xact("wr3", 1'b1, 4'd3, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact("rd3", 1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // Stalled: a pending write to addr 0 must not be accepted
    drive(1'b1, 1'b1, 4'd0, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("stall_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("stall_rdata", 64'(bus.rsp_rdata), 64'(32'hDEAD_BEEF));
      check("stall_req_ready", 64'(bus.req_ready), 64'(0));
      step();
    end
    drive(1'b0, 1'b1, 4'd0, 32'h1234_5678, 1'b1);
    check("consume_req_ready", 64'(bus.req_ready), 64'(1));
    step();
    check("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("idle_req_ready", 64'(bus.req_ready), 64'(1));

    // Back-to-back reads 0, 1, 3; FSM stays in RESP throughout
    xact("b2b0", 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    xact("b2b1", 1'b0, 4'd1, 32'h0, 32'h0, 1'b0);
    xact("b2b3", 1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Read-after-write, last implemented register, neighbour isolation
    xact("wr5", 1'b1, 4'd5, 32'hA5A5_5A5A, 32'h0, 1'b0);
    xact("rd5", 1'b0, 4'd5, 32'h0, 32'hA5A5_5A5A, 1'b0);
    xact("wr11", 1'b1, 4'd11, 32'h0000_0B0B, 32'h0, 1'b0);
    xact("rd11", 1'b0, 4'd11, 32'h0, 32'h0000_0B0B, 1'b0);
    xact("rd4", 1'b0, 4'd4, 32'h0, 32'h0, 1'b0);
    xact("rd6", 1'b0, 4'd6, 32'h0, 32'h0, 1'b0);

    // Unimplemented addresses
    xact("wr14", 1'b1, 4'd14, 32'h5, 32'h0, ErrEn);
    xact("rd14", 1'b0, 4'd14, 32'h0, 32'h0, ErrEn);
    xact("rd12", 1'b0, 4'd12, 32'h0, 32'h0, ErrEn);
    xact("wr12", 1'b1, 4'd12, 32'hFFFF_FFFF, 32'h0, ErrEn);
    xact("rd3_after", 1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xact("rd5_after", 1'b0, 4'd5, 32'h0, 32'hA5A5_5A5A, 1'b0);
    xact("rd10_after", 1'b0, 4'd10, 32'h0, 32'h0, 1'b0);
    xact("rd0_after", 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);

    // Reset while holding unconsumed read data
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
    step();
    xact("pre_rst_rd3", 1'b0, 4'd3, 32'h0, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    areset = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("midrst_rdata", 64'(bus.rsp_rdata), 64'(0));
    check("midrst_req_ready", 64'(bus.req_ready), 64'(0));
    step();
    areset = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
    step();
    check("postrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("postrst_req_ready", 64'(bus.req_ready), 64'(1));
    xact("postrst_rd3", 1'b0, 4'd3, 32'h0, 32'h0, 1'b0);
    xact("postrst_rd5", 1'b0, 4'd5, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
    step();
    check("final_rsp_valid", 64'(bus.rsp_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucore_port_responder.md
UCORE_PORT_RESPONDER -- requirements
Module: ucore_port_responder

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, default 32, request/response data width.
- ADDR_W, default 4, request address width.
- NUM_REGS, default 12, number of implemented registers (1 to 2**ADDR_W).
REQ-002 The block SHALL have these ports:
- clk  input  1  global clock; all state updates on its rising edge.
- areset  input  1  asynchronous reset, active high.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder accepts a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  register index.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response held for the core.
- rsp_ready  input  1  core consumes the response this cycle.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- rsp_err  output  1  request addressed an unimplemented register.
REQ-003 The block SHALL have one clock (clk) and an asynchronous active-high reset (areset).

Function
REQ-004 A request handshake SHALL occur when req_valid and req_ready are both 1 on a rising clk edge; a response handshake SHALL occur when rsp_valid and rsp_ready are both 1.
REQ-005 The block SHALL implement a two-state FSM:
- IDLE: rsp_valid=0, req_ready=1.
- RESP: rsp_valid=1, req_ready=rsp_ready.
REQ-006 In IDLE, an accepted request SHALL complete in one cycle: the write is performed or the read data is captured, and the next state is RESP. Response latency is exactly 1 cycle after acceptance.
REQ-007 In RESP with rsp_ready=0, the FSM SHALL stay in RESP. rsp_rdata and rsp_err SHALL stay stable and no request is accepted.
REQ-008 In RESP with rsp_ready=1 and req_valid=1, the new request SHALL be accepted in the same cycle and the FSM SHALL stay in RESP. This gives back-to-back throughput of 1 per cycle.
REQ-009 In RESP with rsp_ready=1 and req_valid=0, the next state SHALL be IDLE.
REQ-010 An accepted write to addr<NUM_REGS SHALL update regs[addr] at that edge. The response SHALL have rsp_rdata=0 and rsp_err=0.
REQ-011 An accepted read SHALL return the value of regs[addr] as it stands at acceptance. A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-012 Requests to addr>=NUM_REGS SHALL not modify any register and SHALL return rsp_rdata=0; rsp_err follows REQ-017/018.
REQ-013 req_write, req_addr and req_wdata SHALL be ignored whenever no request handshake occurs.
REQ-014 Only the addressed register SHALL change on a write; no other register changes.

Reset
REQ-015 While areset=1, regardless of clk:
- the FSM SHALL be in IDLE;
- outputs SHALL be rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
req_ready SHALL become 1 on the first clk edge after areset deasserts.
REQ-016 On reset assertion mid-transaction:
- all registers SHALL clear to 0;
- any pending response SHALL be discarded;
- no response to a pre-reset request SHALL ever appear.

Configuration
REQ-017 With UCORE_RESPONDER_ERR_EN defined, rsp_err SHALL be 1 in the response to any request with addr>=NUM_REGS, and 0 otherwise.
REQ-018 Without UCORE_RESPONDER_ERR_EN, the rsp_err port SHALL still exist and SHALL be tied to 0. All other behaviour is unchanged.

Verification
REQ-019 Reset, then write addr=3 data=0xDEADBEEF with rsp_ready=1 -> req_ready=1, then rsp_valid=1 one cycle later with rsp_rdata=0 and rsp_err=0.
REQ-020 Read addr=3 immediately after REQ-019, with rsp_ready held 0 for 4 cycles -> rsp_valid=1 and rsp_rdata=0xDEADBEEF stable for all 4 cycles, req_ready=0, then return to IDLE after the consume.
REQ-021 Back-to-back: reads of addrs 0, 1 and 3 on consecutive cycles with rsp_ready=1 -> 3 responses on consecutive cycles, values 0, 0, 0xDEADBEEF, FSM never in IDLE between them.
REQ-022 Write addr=14 data=0x5 (NUM_REGS=12) -> rsp_err=1 with the macro defined and 0 without it; a following read of addr=14 returns 0; all regs are unchanged.
REQ-023 Assert areset while in RESP holding unconsumed read data -> rsp_valid=0 immediately; after deassert, reading addr=3 returns 0.
